// File: rtl/ser_frame_scheduler.sv
// Round-robin arbiter that frames one granted word per transfer onto a single serial line:
// start flag, zero-run-limited (bit-stuffed) payload MSB first, end flag, then an idle gap.
module ser_frame_scheduler #(
  parameter int NREQ       = 4,
  parameter int DATA_W     = 16,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   reqData,
  output logic [NREQ-1:0]          grant,
  output logic                     done,
  output logic                     busy,
  output logic                     txLine
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(DATA_W + GAP_CYCLES + 9);
  localparam logic [7:0] START_FLAG = 8'b0111_1110;
  localparam logic [7:0] END_FLAG   = 8'b1000_0001;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STUFF = 3'd3,
    S_END   = 3'd4,
    S_GAP   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [2:0]         zrun_q, zrun_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               tx_q, tx_d;

  logic               hit_s;
  logic [PTR_W-1:0]   idx_s, win_s;
  logic [2:0]         zrun_inc_s;

  // Round-robin search starting at rr_q, wrapping around the requester set
  always_comb begin
    hit_s = 1'b0;
    win_s = '0;
    idx_s = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx_s = PTR_W'((int'(rr_q) + off) % NREQ);
      if (!hit_s && req[idx_s]) begin
        hit_s = 1'b1;
        win_s = idx_s;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Frame sequencing: next-state and next-output values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    zrun_d     = zrun_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    tx_d       = 1'b1;
    zrun_inc_s = zrun_q + 3'd1;
    case (state_q)
      S_IDLE: begin
        if (hit_s) begin
          grant_d = NREQ'(1'b1) << win_s;
          shift_d = reqData[win_s*DATA_W +: DATA_W];
          rr_d    = PTR_W'((int'(win_s) + 1) % NREQ);
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        tx_d = START_FLAG[3'd7 - cnt_q[2:0]];
        if (cnt_q == CNT_W'(7)) begin
          cnt_d   = '0;
          zrun_d  = 3'd1;  // the flag's trailing 0 opens the first zero run
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        tx_d    = shift_q[DATA_W-1];
        shift_d = {shift_q[DATA_W-2:0], 1'b0};
        zrun_d  = shift_q[DATA_W-1] ? 3'd0 : zrun_inc_s;
        cnt_d   = cnt_q + CNT_W'(1);
        // A stuff pending after the last bit is still sent; STUFF then sees cnt == DATA_W
        if (!shift_q[DATA_W-1] && (zrun_inc_s == 3'd5)) begin
          state_d = S_STUFF;
        end else if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          state_d = S_DATA;
        end
      end
      S_STUFF: begin
        zrun_d = 3'd0;
        if (cnt_q == CNT_W'(DATA_W)) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          state_d = S_DATA;
        end
      end
      S_END: begin
        if (cnt_q == CNT_W'(8)) begin
          done_d  = 1'b1;
          grant_d = '0;
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          tx_d  = END_FLAG[3'd7 - cnt_q[2:0]];
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        cnt_d   = '0;
        zrun_d  = 3'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      zrun_q  <= 3'd0;
      rr_q    <= '0;
      grant_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      zrun_q  <= zrun_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tx_q    <= tx_d;
    end
  end

  assign grant  = grant_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign txLine = tx_q;

endmodule

// File: tb/tb_ser_frame_scheduler.sv
// Directed bench for ser_frame_scheduler: captures each frame off the line, destuffs it and
// checks flags, payload, grant order, gap timing and reset abort.
module tb_ser_frame_scheduler;

  localparam int NREQ   = 4;
  localparam int DATA_W = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req;
  logic [NREQ*DATA_W-1:0] reqData;
  logic [NREQ-1:0]        grant;
  logic                   done;
  logic                   busy;
  logic                   txLine;

  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total    = 0;
  logic line_q[$];
  logic [63:0] line_v;

  ser_frame_scheduler #(.NREQ(NREQ), .DATA_W(DATA_W), .GAP_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .reqData(reqData),
    .grant(grant), .done(done), .busy(busy), .txLine(txLine)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else begin
      fail_cnt = fail_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant === '0 && n < 40) begin
      step();
      n++;
    end
    check("grant_rise", 64'(|grant), 64'(1));
  endtask

  // Collect one frame after grant is seen; drop the owner's req on done
  task automatic frame(input string tag, input logic [NREQ-1:0] exp_g,
                       input logic [DATA_W-1:0] exp_w, input int exp_len,
                       input int mid_cyc, input logic [NREQ-1:0] mid_req);
    logic got_done, g_ok, viol, skip, b;
    logic [7:0] sf, ef;
    logic [DATA_W-1:0] word;
    int n, zr, cntb;
    check({tag, "_grant"}, 64'(grant), 64'(exp_g));
    line_q.delete();
    line_v = '0;
    got_done = 1'b0;
    g_ok = 1'b1;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (c == mid_cyc) begin
        req = mid_req;
        reqData = ~reqData;
      end
      step();
      if (done === 1'b1) got_done = 1'b1;
      else begin
        line_q.push_back(txLine);
        line_v = {line_v[62:0], txLine};
        if (grant !== exp_g) g_ok = 1'b0;
      end
    end
    req = req & ~exp_g;
    check({tag, "_done_seen"}, 64'(got_done), 64'(1));
    check({tag, "_grant_at_done"}, 64'(grant), 64'(0));
    check({tag, "_grant_held"}, 64'(g_ok), 64'(1));
    n = line_q.size();
    if (exp_len > 0) check({tag, "_len"}, 64'(n), 64'(exp_len));
    sf = '0; ef = '0; word = '0; viol = 1'b0; skip = 1'b0; zr = 1; cntb = 0;
    if (n >= 16) begin
      for (int j = 0; j < 8; j++) begin
        sf = {sf[6:0], line_q[j]};
        ef = {ef[6:0], line_q[n-8+j]};
      end
      for (int j = 8; j < n - 8; j++) begin
        b = line_q[j];
        if (j + 7 < n - 8) begin
          if (line_q[j] && !line_q[j+1] && !line_q[j+2] && !line_q[j+3] && !line_q[j+4] &&
              !line_q[j+5] && !line_q[j+6] && line_q[j+7]) viol = 1'b1;
        end
        if (skip) begin
          if (b !== 1'b1) viol = 1'b1;
          skip = 1'b0;
          zr = 0;
        end else begin
          word = {word[DATA_W-2:0], b};
          cntb++;
          if (b === 1'b0) zr++;
          else zr = 0;
          if (zr >= 6) viol = 1'b1;
          if (zr == 5) skip = 1'b1;
        end
      end
    end else viol = 1'b1;
    check({tag, "_start_flag"}, 64'(sf), 64'(8'h7E));
    check({tag, "_end_flag"}, 64'(ef), 64'(8'h81));
    check({tag, "_payload_bits"}, 64'(cntb), 64'(DATA_W));
    check({tag, "_word"}, 64'(word), 64'(exp_w));
    check({tag, "_line_rules"}, 64'({viol, skip}), 64'(0));
  endtask

  initial begin
    int n;
    int sel;
    logic [DATA_W-1:0] w;
    logic [DATA_W-1:0] w2;
    logic [34:0] exp35;
    rst = 1'b1;
    req = '0;
    reqData = '0;
    step();
    step();
    check("rst_txLine", 64'(txLine), 64'(1));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    rst = 1'b0;

    // All-zero payload: three stuffed bits
    reqData[0 +: DATA_W] = 16'h0000;
    req = 4'b0001;
    wait_grant(n);
    check("t1_grant_latency", 64'(n), 64'(1));
    check("t1_busy", 64'(busy), 64'(1));
    frame("t1", 4'b0001, 16'h0000, 35, -1, 4'b0000);
    exp35 = {8'h7E, 19'b0000100000100000100, 8'h81};
    check("t1_line", 64'(line_v[34:0]), 64'(exp35));
    step();
    check("t1_done_pulse", 64'(done), 64'(0));
    check("t1_gap1", 64'({txLine, busy}), 64'(2'b11));
    step();
    check("t1_gap2", 64'({txLine, busy}), 64'(2'b10));

    // All-ones payload: no stuffing
    reqData[DATA_W +: DATA_W] = 16'hFFFF;
    req = 4'b0010;
    wait_grant(n);
    frame("t2", 4'b0010, 16'hFFFF, 32, -1, 4'b0000);
    check("t2_line", 64'(line_v[31:0]), 64'(32'h7EFFFF81));

    // Round-robin from reset with all requesters active
    rst = 1'b1;
    step();
    rst = 1'b0;
    reqData = 64'h8001_1234_0F00_A5A5;
    req = 4'b1111;
    wait_grant(n);
    frame("t3a", 4'b0001, 16'hA5A5, 0, -1, 4'b0000);
    wait_grant(n);
    check("t3_gap_latency", 64'(n), 64'(3));
    frame("t3b", 4'b0010, 16'h0F00, 0, -1, 4'b0000);
    wait_grant(n);
    frame("t3c", 4'b0100, 16'h1234, 0, -1, 4'b0000);
    wait_grant(n);
    frame("t3d", 4'b1000, 16'h8001, 0, -1, 4'b0000);
    check("t3_req_cleared", 64'(req), 64'(0));
    for (int i = 0; i < 6; i++) step();
    check("t3_idle", 64'({busy, grant}), 64'(0));
    req = 4'b1111;
    wait_grant(n);
    check("t3_wrap_grant", 64'(grant), 64'(4'b0001));

    // Abort by reset in the middle of the payload
    for (int i = 0; i < 13; i++) step();
    check("t5_busy_before", 64'(busy), 64'(1));
    rst = 1'b1;
    req = '0;
    step();
    check("t5_abort", 64'({txLine, grant, busy, done}), 64'({1'b1, 4'b0000, 1'b0, 1'b0}));
    rst = 1'b0;

    // Pointer back at 0; late request arrives mid-frame; stuff after the last payload bit
    reqData = 64'h0000_1234_0000_FFE0;
    req = 4'b1001;
    wait_grant(n);
    w2 = ~reqData[2*DATA_W +: DATA_W];
    frame("t4a", 4'b0001, 16'hFFE0, 33, 10, 4'b0101);
    check("t4_req_left", 64'(req), 64'(4'b0100));
    wait_grant(n);
    check("t4_gap_latency", 64'(n), 64'(3));
    frame("t4b", 4'b0100, w2, 0, -1, 4'b0000);

    // Random payloads through randomly chosen requesters
    for (int it = 0; it < 1000 && fail_cnt < 50; it++) begin
      sel = $urandom_range(0, NREQ - 1);
      w = DATA_W'($urandom);
      reqData = {$urandom, $urandom};
      reqData[sel*DATA_W +: DATA_W] = w;
      req = NREQ'(1) << sel;
      wait_grant(n);
      frame("rnd", NREQ'(1) << sel, w, 0, -1, 4'b0000);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
